// File: rtl/seg7_capture.sv
// Readback of a multiplexed active-low seven-segment bus: debounces each digit,
// decodes it to BCD and emits the assembled frame with a one-cycle valid pulse.
module seg7_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   bcd_word,
    output logic                  word_valid,
    output logic                  frame_err
);

    // state  | meaning
    // IDLE   | sample idle (no anode or several anodes low), counter 0
    // SETTLE | single anode low, counting consecutive identical samples
    // HELD   | digit accepted, waiting for the sample to change
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HELD} state_t;

    localparam int              IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]      STABLE = 8'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] ONE  = DIGITS'(1);

    logic [6:0]          r_s_seg;
    logic [DIGITS-1:0]   r_s_an;
    state_t              r_state;
    state_t              w_state_nx;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nx;
    logic [DIGITS-1:0]   r_mask;
    logic [DIGITS-1:0]   w_mask_nx;
    logic                r_err;
    logic                w_err_nx;
    logic [4*DIGITS-1:0] r_slots;

    logic [DIGITS-1:0]   w_onehot;
    logic                w_active;
    logic                w_same;
    logic [IDX_W-1:0]    w_idx;
    logic [6:0]          w_seg_on;
    logic [3:0]          w_nib;
    logic                w_bad;
    logic                w_capture;
    logic                w_done;

    // The sample entering s_* is judged against the one already held there,
    // so the capture edge is also the edge that loads the last stable sample.
    assign w_onehot = ~an_n;
    assign w_active = (w_onehot != '0) && ((w_onehot & (w_onehot - ONE)) == '0);
    assign w_same   = ({seg_n, an_n} == {r_s_seg, r_s_an});
    assign w_seg_on = ~seg_n;
    assign w_done   = &r_mask;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_onehot[i]) w_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_bad = 1'b0;
        case (w_seg_on)
            7'b1111110: w_nib = 4'h0;
            7'b0110000: w_nib = 4'h1;
            7'b1101101: w_nib = 4'h2;
            7'b1111001: w_nib = 4'h3;
            7'b0110011: w_nib = 4'h4;
            7'b1011011: w_nib = 4'h5;
            7'b1011111: w_nib = 4'h6;
            7'b1110000: w_nib = 4'h7;
            7'b1111111: w_nib = 4'h8;
            7'b1111011: w_nib = 4'h9;
            7'b0000000: w_nib = 4'hF;
            default: begin
                w_nib = 4'hE;
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (w_active) w_state_nx = ST_SETTLE;
            ST_SETTLE: begin
                if (!w_active)                            w_state_nx = ST_IDLE;
                else if (w_same && r_cnt == STABLE - 8'd1) w_state_nx = ST_HELD;
                else                                      w_state_nx = ST_SETTLE;
            end
            ST_HELD: begin
                if (!w_active)    w_state_nx = ST_IDLE;
                else if (!w_same) w_state_nx = ST_SETTLE;
            end
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_cnt_nx  = r_cnt;
        case (r_state)
            ST_IDLE:   w_cnt_nx = w_active ? 8'd1 : 8'd0;
            ST_SETTLE: begin
                if (!w_active)    w_cnt_nx = 8'd0;
                else if (!w_same) w_cnt_nx = 8'd1;
                else begin
                    w_cnt_nx = r_cnt + 8'd1;
                    if (r_cnt == STABLE - 8'd1) w_capture = 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_active)    w_cnt_nx = 8'd0;
                else if (!w_same) w_cnt_nx = 8'd1;
                else              w_cnt_nx = STABLE;
            end
            default:   w_cnt_nx = 8'd0;
        endcase
    end

    // A capture on the completion edge lands in the freshly cleared mask.
    always_comb begin
        w_mask_nx = w_done ? '0 : r_mask;
        w_err_nx  = w_done ? 1'b0 : r_err;
        if (w_capture) begin
            w_mask_nx[w_idx] = 1'b1;
            w_err_nx         = w_err_nx | w_bad;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s_seg    <= 7'h7F;
            r_s_an     <= '1;
            r_cnt      <= 8'd0;
            r_mask     <= '0;
            r_err      <= 1'b0;
            r_slots    <= '0;
            bcd_word   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_s_seg    <= seg_n;
            r_s_an     <= an_n;
            r_cnt      <= w_cnt_nx;
            r_mask     <= w_mask_nx;
            r_err      <= w_err_nx;
            word_valid <= w_done;
            frame_err  <= w_done & r_err;
            if (w_done)    bcd_word <= r_slots;
            if (w_capture) r_slots[{w_idx, 2'b00} +: 4] <= w_nib;
        end
    end

endmodule
